// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: stalls, flushes, forwarding and MDU sequencing.
// Optional performance counters (stall_cycles, flush_cycles) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
    parameter int WIDTH_5  = 5,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH_5-1:0] Rs_D,
    input  logic [WIDTH_5-1:0] Rt_D,
    input  logic [WIDTH_5-1:0] Rs_E,
    input  logic [WIDTH_5-1:0] Rt_E,
    input  logic [WIDTH_5-1:0] WriteReg_E,
    input  logic [WIDTH_5-1:0] WriteReg_M,
    input  logic [WIDTH_5-1:0] WriteReg_W,
    input  logic               RegWrite_E,
    input  logic               RegWrite_M,
    input  logic               RegWrite_W,
    input  logic               MemtoReg_E,
    input  logic               MemtoReg_M,
    input  logic               Branch_D,
    input  logic               Jr_D,
    input  logic               J_D,
    input  logic               PCSrc_D,
    input  logic               mdu_start_E,
    input  logic               mdu_is_div_E,
    output logic               EN_F,
    output logic               EN_FD,
    output logic               CLR_FD,
    output logic               EN_DE,
    output logic               CLR_DE,
    output logic               bubble_EM,
    output logic [1:0]         ForwardA_E,
    output logic [1:0]         ForwardB_E,
    output logic               ForwardA_D,
    output logic               ForwardB_D,
    output logic               mdu_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_cycles,
`endif
    output logic               mdu_done
);

    typedef enum logic [1:0] {RUN, MDU_WAIT, MDU_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lwstall, branchstall, stall_d;

    function automatic logic [1:0] fwd_e(input logic [WIDTH_5-1:0] src,
                                         input logic [WIDTH_5-1:0] wr_m, input logic we_m,
                                         input logic [WIDTH_5-1:0] wr_w, input logic we_w);
        if (src != '0 && we_m && src == wr_m)      return 2'b10;
        else if (src != '0 && we_w && src == wr_w) return 2'b01;
        else                                       return 2'b00;
    endfunction

    // A branch source is not yet available if Execute will write it, or Memory holds a load to it.
    function automatic logic src_busy(input logic [WIDTH_5-1:0] src);
        return (src != '0) && ((RegWrite_E && WriteReg_E == src) || (MemtoReg_M && WriteReg_M == src));
    endfunction

    always_comb begin
        lwstall     = MemtoReg_E && RegWrite_E && (WriteReg_E != '0) &&
                      (WriteReg_E == Rs_D || WriteReg_E == Rt_D);
        branchstall = (Branch_D && (src_busy(Rs_D) || src_busy(Rt_D))) || (Jr_D && src_busy(Rs_D));
        stall_d     = lwstall || branchstall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = RUN;
        cnt_d     = cnt_q;
        EN_F      = 1'b1;
        EN_FD     = 1'b1;
        EN_DE     = 1'b1;
        CLR_FD    = 1'b0;
        CLR_DE    = 1'b0;
        bubble_EM = 1'b0;
        mdu_busy  = 1'b0;
        mdu_done  = 1'b0;
        if (state_q == MDU_WAIT) begin
            EN_F      = 1'b0;
            EN_FD     = 1'b0;
            EN_DE     = 1'b0;
            bubble_EM = 1'b1;
            mdu_busy  = 1'b1;
            if (cnt_q == '0) begin
                mdu_done = 1'b1;
                state_d  = MDU_RELEASE;
            end else begin
                cnt_d   = cnt_q - 1'b1;
                state_d = MDU_WAIT;
            end
        end else if (state_q == RUN && mdu_start_E) begin
            // The start cycle counts toward the hold, and the final WAIT cycle is counter==0.
            EN_F      = 1'b0;
            EN_FD     = 1'b0;
            EN_DE     = 1'b0;
            bubble_EM = 1'b1;
            mdu_busy  = 1'b1;
            cnt_d     = mdu_is_div_E ? CNT_W'(DIV_LAT - 2) : CNT_W'(MULT_LAT - 2);
            state_d   = MDU_WAIT;
        end else if (stall_d) begin
            EN_F   = 1'b0;
            EN_FD  = 1'b0;
            EN_DE  = 1'b0;
            CLR_DE = 1'b1;
        end else if (PCSrc_D || J_D || Jr_D) begin
            EN_FD  = 1'b0;
            CLR_FD = 1'b1;
        end
        if (!rst_n) begin
            EN_F      = 1'b0;
            EN_FD     = 1'b0;
            EN_DE     = 1'b0;
            CLR_FD    = 1'b1;
            CLR_DE    = 1'b1;
            bubble_EM = 1'b0;
            mdu_busy  = 1'b0;
            mdu_done  = 1'b0;
        end
    end

    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        ForwardA_D = 1'b0;
        ForwardB_D = 1'b0;
        if (rst_n) begin
            ForwardA_E = fwd_e(Rs_E, WriteReg_M, RegWrite_M, WriteReg_W, RegWrite_W);
            ForwardB_E = fwd_e(Rt_E, WriteReg_M, RegWrite_M, WriteReg_W, RegWrite_W);
            ForwardA_D = (Rs_D != '0) && RegWrite_M && (WriteReg_M == Rs_D);
            ForwardB_D = (Rt_D != '0) && RegWrite_M && (WriteReg_M == Rt_D);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, ~EN_F};
        flush_cycles_d = flush_cycles_q + {31'd0, CLR_FD};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Drives the EN/CLR pair of the Fetch/Decode and Decode/Execute pipeline registers.
- Generates forwarding selects for the Decode and Execute stages.
- Sequences the multi-cycle multiply/divide unit (MDU) by holding the pipeline until the result is ready.

Parameters:
- WIDTH_5, 5, register-index width.
- MULT_LAT, 4, MDU cycles for mult/multu (must be >= 2).
- DIV_LAT, 32, MDU cycles for div/divu (must be >= 2).
- CNT_W, 6, width of the MDU latency counter (must satisfy 2^CNT_W > max latency).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- Rs_D, Rt_D  in  5 each  Decode-stage source register indices.
- Rs_E, Rt_E  in  5 each  Execute-stage source register indices.
- WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination register per stage.
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  write enable per stage.
- MemtoReg_E, MemtoReg_M  in  1 each  load-in-stage flags.
- Branch_D  in  1  conditional branch in Decode.
- Jr_D, J_D  in  1 each  jump-register and jump in Decode.
- PCSrc_D  in  1  branch resolved as taken.
- mdu_start_E  in  1  mult/div instruction present in Execute.
- mdu_is_div_E  in  1  1 = div, 0 = mult.
- EN_F  out  1  PC register enable.
- EN_FD, CLR_FD  out  1 each  Fetch/Decode register control.
- EN_DE, CLR_DE  out  1 each  Decode/Execute register control.
- bubble_EM  out  1  insert a NOP into the Execute/Memory register.
- ForwardA_E, ForwardB_E  out  2 each  Execute operand select: 00 = register file, 10 = Memory stage, 01 = Writeback stage.
- ForwardA_D, ForwardB_D  out  1 each  Decode branch-compare forward from the Memory stage.
- mdu_busy  out  1  MDU operating.
- mdu_done  out  1  one-cycle pulse on the final MDU cycle.

Behaviour:
- Pipeline registers give EN priority over CLR. A flush is therefore always driven as EN=0, CLR=1. A hold is EN=0, CLR=0.
- FSM states: RUN, MDU_WAIT, MDU_RELEASE. The state and the CNT_W-bit counter are registered. All other outputs are combinational from the state, the counter and the inputs.
- Reset (rst_n low, asynchronous):
  - state=RUN, counter=0.
  - Outputs forced: EN_F=EN_FD=EN_DE=0, CLR_FD=CLR_DE=1, bubble_EM=0, all forwards=0, mdu_busy=0, mdu_done=0.
  - Reset asserted mid-MDU aborts the operation immediately.
- lwstall = MemtoReg_E & RegWrite_E & WriteReg_E!=0 & (WriteReg_E==Rs_D | WriteReg_E==Rt_D).
- branchstall, for Branch_D (Rs_D or Rt_D) or Jr_D (Rs_D only), raised when the source matches:
  - a nonzero WriteReg_E with RegWrite_E, or
  - a nonzero WriteReg_M with MemtoReg_M.
- stall_D = lwstall | branchstall.
- RUN:
  - Default: all EN=1, all CLR=0.
  - If mdu_start_E: load counter = LAT-2 (MULT_LAT or DIV_LAT from mdu_is_div_E), go to MDU_WAIT, hold F/FD/DE this cycle, bubble_EM=1, mdu_busy=1.
  - Else if stall_D: EN_F=0, EN_FD=0, EN_DE=0, CLR_DE=1 (bubble into Execute).
  - Else if PCSrc_D | J_D | Jr_D: EN_FD=0, CLR_FD=1 (flush the wrong-path fetch); EN_F=1, EN_DE=1.
- MDU_WAIT:
  - Hold F/FD/DE, bubble_EM=1, mdu_busy=1.
  - Counter decrements each cycle. Hazard inputs and new mdu_start_E are ignored.
  - When counter==0: mdu_done=1 for that cycle, go to MDU_RELEASE.
  - Total hold = LAT cycles, counting the RUN start cycle.
- MDU_RELEASE:
  - One cycle, behaves as RUN with mdu_start_E treated as 0, so the held instruction is not reissued. Stall/flush rules still apply.
  - mdu_busy=0, then return to RUN.
- Execute forwarding, applied to A and B independently:
  - Select 10 when Rs_E (or Rt_E) is nonzero and equals WriteReg_M with RegWrite_M.
  - Otherwise select 01 when it equals WriteReg_W with RegWrite_W.
  - Otherwise select 00. The Memory stage has priority.
- Decode forwarding: ForwardA_D = Rs_D!=0 & RegWrite_M & WriteReg_M==Rs_D. ForwardB_D is the same rule using Rt_D.
- Register 0 never causes a stall or a forward.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_cycles[31:0]:
  - stall_cycles increments on every cycle with EN_F=0 outside reset.
  - flush_cycles increments on every cycle with CLR_FD=1 outside reset.
  - Both are asynchronously reset to 0 and wrap on overflow from 0xFFFFFFFF to 0.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- lw $8 in Execute (MemtoReg_E=1, RegWrite_E=1, WriteReg_E=8), Rs_D=8 -> one cycle of EN_F=0, EN_FD=0, EN_DE=0, CLR_DE=1; next cycle all EN=1.
- Rs_E=5, WriteReg_M=5 with RegWrite_M=1 and WriteReg_W=5 with RegWrite_W=1 -> ForwardA_E=10. With RegWrite_M=0 -> 01. With Rs_E=0 -> 00.
- PCSrc_D=1, no stall -> EN_FD=0, CLR_FD=1, EN_DE=1 for one cycle.
- mdu_start_E=1, mdu_is_div_E=0, MULT_LAT=4 -> F/FD/DE held and bubble_EM=1 for 4 cycles; mdu_done high on the 4th; following cycle advances without restart.
- Div started, rst_n pulsed low on cycle 10 -> asynchronous return to RUN with reset output values; after release, normal RUN, mdu_busy=0.
- Beq in Decode with Rs_D=9, RegWrite_E=1, WriteReg_E=9 -> branchstall for 1 cycle; next cycle ForwardA_D=1 when WriteReg_M=9 with RegWrite_M=1.
